// File: rtl/spatial_mult_pkg.sv
// Shared helpers for the spatial multiplier operand path: clog2, the B-operand
// digit permutation used by both the forward mux and its inverse, and the
// serializer state encoding.
package spatial_mult_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } b_unmux_state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Permuted digit position of natural digit nat_idx (= c + r*N).
  // The recursive quadrant split (q = {row_half, col_half}, each quadrant
  // permuted again) flattens to an interleave of row/column bits with the row
  // bit more significant at every level. The top transposing mux swaps (r,c)
  // before the split.
  function automatic int b_mux_index(input int p, input int l, input bit transpose,
                                     input int nat_idx);
    int n, r, c, t, sz, h, idx;
    n = p / l;
    r = nat_idx / n;
    c = nat_idx % n;
    if (transpose) begin
      t = r;
      r = c;
      c = t;
    end
    idx = 0;
    sz  = n;
    for (int k = 0; k < 16; k++) begin
      if (sz > 1) begin
        h   = sz / 2;
        idx = idx + (((r >= h) ? 2 : 0) + ((c >= h) ? 1 : 0)) * h * h;
        r   = r % h;
        c   = c % h;
        sz  = h;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/b_unmux_perm.sv
// Combinational inverse of the B-operand quadrant mux: pure wiring that
// places every permuted digit back at its natural row-major position.
module b_unmux_perm
  import spatial_mult_pkg::*;
#(
  parameter int PRECISION   = 8,
  parameter int L_PRECISION = 2,
  parameter int TRANSPOSE   = 1,
  localparam int N          = PRECISION / L_PRECISION,
  localparam int DATA_WIDTH = N * PRECISION
) (
  input  logic [DATA_WIDTH-1:0] perm_data_i,
  output logic [DATA_WIDTH-1:0] nat_data_o
);

  // Natural digit gi is read from wherever the forward mux sent it.
  for (genvar gi = 0; gi < N * N; gi++) begin : g_digit
    localparam int SRC = b_mux_index(PRECISION, L_PRECISION, bit'(TRANSPOSE != 0), gi);
    assign nat_data_o[gi*L_PRECISION +: L_PRECISION] = perm_data_i[SRC*L_PRECISION +: L_PRECISION];
  end

endmodule

// File: rtl/b_unmux_serializer.sv
// Readback serializer for permuted B operands: accepts one quadrant-permuted
// vector, un-permutes it into a buffer and streams it out one natural-order
// row per beat, accepting the next vector on the final row without a bubble.
// Optional feature macro: B_UNMUX_ROW_LAST_EN adds the out_last output.
module b_unmux_serializer
  import spatial_mult_pkg::*;
#(
  parameter int PRECISION   = 8,
  parameter int L_PRECISION = 2,
  parameter int TRANSPOSE   = 1,
  localparam int N          = PRECISION / L_PRECISION,
  localparam int DATA_WIDTH = N * PRECISION,
  localparam int ROW_W      = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PRECISION-1:0]  out_data,
`ifdef B_UNMUX_ROW_LAST_EN
  output logic [ROW_W-1:0]      out_row,
  output logic                  out_last
`else
  output logic [ROW_W-1:0]      out_row
`endif
);

  b_unmux_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] nat_data;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  last_row;
  logic [PRECISION-1:0]  row_data [N];

  b_unmux_perm #(
    .PRECISION  (PRECISION),
    .L_PRECISION(L_PRECISION),
    .TRANSPOSE  (TRANSPOSE)
  ) u_perm (
    .perm_data_i(in_data),
    .nat_data_o (nat_data)
  );

  assign last_row = (row_q == ROW_W'(N - 1));

  // Split the buffered operand into rows; row r holds natural digits (r,*).
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    assign row_data[gi] = buf_q[gi*PRECISION +: PRECISION];
  end

  assign out_data = row_data[row_q];
  assign out_row  = row_q;
`ifdef B_UNMUX_ROW_LAST_EN
  assign out_last = out_valid && last_row;
`endif

  // State, buffer and row counter; reset discards any vector in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      row_q   <= row_d;
    end
  end

  // Next state and handshakes; on the final row's handshake a waiting vector
  // is taken directly so consecutive vectors stream with no idle cycle.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    row_d     = row_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d   = nat_data;
          row_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        in_ready  = last_row && out_ready;
        if (out_ready) begin
          if (!last_row) begin
            row_d = row_q + ROW_W'(1);
          end else if (in_valid) begin
            buf_d = nat_data;
            row_d = '0;
          end else begin
            row_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_b_unmux_serializer.sv
// Self-checking bench for b_unmux_serializer: two P=4 instances for the fixed
// example vectors and two P=8 instances (TRANSPOSE 1 and 0) driven in lockstep
// with random operands passed through a quadrant-splitting forward mux model.
module tb_b_unmux_serializer;

  localparam int P = 8;
  localparam int L = 2;
  localparam int N = P / L;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // P=4 pair
  logic       s_in_valid, s_out_ready;
  logic [7:0] s_in_data;
  logic       s1_in_ready, s1_out_valid, s0_in_ready, s0_out_valid;
  logic [3:0] s1_out_data, s0_out_data;
  logic [0:0] s1_out_row, s0_out_row;
  // P=8 pair
  logic        in_valid, out_ready;
  logic [31:0] d1_in, d0_in;
  logic        t1_in_ready, t1_out_valid, t0_in_ready, t0_out_valid;
  logic [7:0]  t1_out_data, t0_out_data;
  logic [1:0]  t1_out_row, t0_out_row;
`ifdef B_UNMUX_ROW_LAST_EN
  logic s1_out_last, s0_out_last, t1_out_last, t0_out_last;
`endif

  int n_vec = 0;
  int n_err = 0;
  int ord_r [N*N];
  int ord_c [N*N];

  always #5 clk = ~clk;

  b_unmux_serializer #(.PRECISION(4), .L_PRECISION(2), .TRANSPOSE(1)) dut_s1 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s1_in_ready),
    .in_data(s_in_data), .out_valid(s1_out_valid), .out_ready(s_out_ready),
    .out_data(s1_out_data),
`ifdef B_UNMUX_ROW_LAST_EN
    .out_row(s1_out_row), .out_last(s1_out_last)
`else
    .out_row(s1_out_row)
`endif
  );

  b_unmux_serializer #(.PRECISION(4), .L_PRECISION(2), .TRANSPOSE(0)) dut_s0 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s0_in_ready),
    .in_data(s_in_data), .out_valid(s0_out_valid), .out_ready(s_out_ready),
    .out_data(s0_out_data),
`ifdef B_UNMUX_ROW_LAST_EN
    .out_row(s0_out_row), .out_last(s0_out_last)
`else
    .out_row(s0_out_row)
`endif
  );

  b_unmux_serializer #(.PRECISION(P), .L_PRECISION(L), .TRANSPOSE(1)) dut_t1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(t1_in_ready),
    .in_data(d1_in), .out_valid(t1_out_valid), .out_ready(out_ready),
    .out_data(t1_out_data),
`ifdef B_UNMUX_ROW_LAST_EN
    .out_row(t1_out_row), .out_last(t1_out_last)
`else
    .out_row(t1_out_row)
`endif
  );

  b_unmux_serializer #(.PRECISION(P), .L_PRECISION(L), .TRANSPOSE(0)) dut_t0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(t0_in_ready),
    .in_data(d0_in), .out_valid(t0_out_valid), .out_ready(out_ready),
    .out_data(t0_out_data),
`ifdef B_UNMUX_ROW_LAST_EN
    .out_row(t0_out_row), .out_last(t0_out_last)
`else
    .out_row(t0_out_row)
`endif
  );

  // Depth-first quadrant walk (q0,q1,q2,q3 at each level) listing which
  // natural (r,c) lands at each permuted digit slot.
  task automatic build_order();
    int sr[$], sc[$], sn[$];
    int r0, c0, n, h, cnt;
    cnt = 0;
    sr.push_back(0); sc.push_back(0); sn.push_back(N);
    while (sn.size() > 0) begin
      r0 = sr.pop_back(); c0 = sc.pop_back(); n = sn.pop_back();
      if (n == 1) begin
        ord_r[cnt] = r0; ord_c[cnt] = c0; cnt++;
      end else begin
        h = n / 2;
        sr.push_back(r0 + h); sc.push_back(c0 + h); sn.push_back(h);
        sr.push_back(r0 + h); sc.push_back(c0);     sn.push_back(h);
        sr.push_back(r0);     sc.push_back(c0 + h); sn.push_back(h);
        sr.push_back(r0);     sc.push_back(c0);     sn.push_back(h);
      end
    end
  endtask

  // Forward mux reference: optional transpose, then quadrant placement.
  function automatic logic [31:0] fwd_mux(input logic [31:0] x, input bit t);
    logic [31:0] y;
    int r, c, src;
    y = '0;
    for (int p = 0; p < N*N; p++) begin
      r = ord_r[p];
      c = ord_c[p];
      src = t ? (r + c*N) : (c + r*N);
      y[p*L +: L] = x[src*L +: L];
    end
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got, want;
    logic [6:0]  sgot;
    #2;
    want = {1'b0, 1'b1, 2'd0, 8'h00};
    got = {t1_out_valid, t1_in_ready, t1_out_row, t1_out_data};
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_t1 {v,rdy,row,data} got %h want %h", got, want); end
    got = {t0_out_valid, t0_in_ready, t0_out_row, t0_out_data};
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_t0 {v,rdy,row,data} got %h want %h", got, want); end
    sgot = {s1_out_valid, s1_in_ready, s1_out_row, s1_out_data};
    n_vec++;
    if (sgot !== 7'b0100000) begin n_err++; $display("FAIL reset_s1 {v,rdy,row,data} got %b want 0100000", sgot); end
`ifdef B_UNMUX_ROW_LAST_EN
    n_vec++;
    if (t1_out_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", t1_out_last); end
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_basic();
    logic [6:0] got;
    s_in_valid = 1'b1; s_in_data = 8'hD8; s_out_ready = 1'b1;
    #1;
    got = {s1_out_valid, s1_in_ready, 5'b0};
    n_vec++;
    if (got !== 7'b0100000) begin n_err++; $display("FAIL basic_pre_accept {v,rdy} got %b want 01", got[6:5]); end
    tick();
    s_in_valid = 1'b0; s_in_data = 8'h5A;
    #1;
    got = {s1_out_valid, s1_in_ready, s1_out_row, s1_out_data};
    n_vec++;
    if (got !== {1'b1, 1'b0, 1'b0, 4'h4}) begin n_err++; $display("FAIL basic_t1_row0 got %b want 1004(hex data 4)", got); end
    got = {s0_out_valid, s0_in_ready, s0_out_row, s0_out_data};
    n_vec++;
    if (got !== {1'b1, 1'b0, 1'b0, 4'h8}) begin n_err++; $display("FAIL basic_t0_row0 got %b want data 8 row 0", got); end
    tick();
    #1;
    got = {s1_out_valid, s1_in_ready, s1_out_row, s1_out_data};
    n_vec++;
    if (got !== {1'b1, 1'b1, 1'b1, 4'hE}) begin n_err++; $display("FAIL basic_t1_row1 got %b want data E row 1", got); end
    got = {s0_out_valid, s0_in_ready, s0_out_row, s0_out_data};
    n_vec++;
    if (got !== {1'b1, 1'b1, 1'b1, 4'hD}) begin n_err++; $display("FAIL basic_t0_row1 got %b want data D row 1", got); end
    tick();
    #1;
    n_vec++;
    if ({s1_out_valid, s0_out_valid} !== 2'b00) begin n_err++; $display("FAIL basic_end valid got %b want 00", {s1_out_valid, s0_out_valid}); end
    s_out_ready = 1'b0;
    $display("basic: in D8 checked rows for TRANSPOSE 1 and 0");
  endtask

  task automatic test_roundtrip();
    logic [31:0] x;
    logic [11:0] got, want;
    for (int k = 0; k < 6; k++) begin
      x = $urandom;
      in_valid = 1'b1; out_ready = 1'b1;
      d1_in = fwd_mux(x, 1'b1); d0_in = fwd_mux(x, 1'b0);
      #1;
      n_vec++;
      if ({t1_out_valid, t1_in_ready, t0_out_valid, t0_in_ready} !== 4'b0101) begin
        n_err++; $display("FAIL rt_idle {v1,r1,v0,r0} got %b want 0101", {t1_out_valid, t1_in_ready, t0_out_valid, t0_in_ready});
      end
      tick();
      in_valid = 1'b0; d1_in = $urandom; d0_in = $urandom;
      for (int i = 0; i < N; i++) begin
        #1;
        want = {1'b1, (i == N-1), 2'(i), x[i*P +: P]};
        got = {t1_out_valid, t1_in_ready, t1_out_row, t1_out_data};
        n_vec++;
        if (got !== want) begin n_err++; $display("FAIL rt_t1 x=%h row %0d got %h want %h", x, i, got, want); end
        got = {t0_out_valid, t0_in_ready, t0_out_row, t0_out_data};
        n_vec++;
        if (got !== want) begin n_err++; $display("FAIL rt_t0 x=%h row %0d got %h want %h", x, i, got, want); end
`ifdef B_UNMUX_ROW_LAST_EN
        n_vec++;
        if ({t1_out_last, t0_out_last} !== {2{i == N-1}}) begin
          n_err++; $display("FAIL rt_last row %0d got %b want %b", i, {t1_out_last, t0_out_last}, {2{i == N-1}});
        end
`endif
        tick();
      end
      #1;
      n_vec++;
      if ({t1_out_valid, t0_out_valid} !== 2'b00) begin n_err++; $display("FAIL rt_end valid got %b want 00", {t1_out_valid, t0_out_valid}); end
      tick();
      $display("roundtrip: x=%h", x);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x;
    logic [11:0] got, want;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int row;
    for (int k = 0; k < 3; k++) begin
      x = $urandom;
      in_valid = 1'b1; out_ready = 1'b0;
      d1_in = fwd_mux(x, 1'b1); d0_in = fwd_mux(x, 1'b0);
      tick();
      in_valid = 1'b0;
      row = 0;
      for (int cyc = 0; cyc < 40 && row < N; cyc++) begin
        out_ready = (cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1));
        d1_in = $urandom; d0_in = $urandom;
        #1;
        want = {1'b1, (row == N-1) && out_ready, 2'(row), x[row*P +: P]};
        got = {t1_out_valid, t1_in_ready, t1_out_row, t1_out_data};
        n_vec++;
        if (got !== want) begin n_err++; $display("FAIL bp_t1 cyc %0d got %h want %h", cyc, got, want); end
        got = {t0_out_valid, t0_in_ready, t0_out_row, t0_out_data};
        n_vec++;
        if (got !== want) begin n_err++; $display("FAIL bp_t0 cyc %0d got %h want %h", cyc, got, want); end
        tick();
        if (out_ready) row++;
      end
      n_vec++;
      if (row != N) begin n_err++; $display("FAIL bp_timeout rows done %0d want %0d", row, N); end
      #1;
      n_vec++;
      if ({t1_out_valid, t0_out_valid} !== 2'b00) begin n_err++; $display("FAIL bp_end valid got %b want 00", {t1_out_valid, t0_out_valid}); end
      out_ready = 1'b0;
      tick();
      $display("backpressure: x=%h", x);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [2];
    logic [31:0] cur;
    logic [11:0] got, want;
    v[0] = $urandom; v[1] = $urandom;
    in_valid = 1'b1; out_ready = 1'b1;
    d1_in = fwd_mux(v[0], 1'b1); d0_in = fwd_mux(v[0], 1'b0);
    tick();
    d1_in = fwd_mux(v[1], 1'b1); d0_in = fwd_mux(v[1], 1'b0);
    for (int i = 0; i < 2*N; i++) begin
      #1;
      cur = v[i / N];
      want = {1'b1, (i % N == N-1), 2'(i % N), cur[(i % N)*P +: P]};
      got = {t1_out_valid, t1_in_ready, t1_out_row, t1_out_data};
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL b2b_t1 beat %0d got %h want %h", i, got, want); end
      got = {t0_out_valid, t0_in_ready, t0_out_row, t0_out_data};
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL b2b_t0 beat %0d got %h want %h", i, got, want); end
      tick();
      if (i == N-1) in_valid = 1'b0;
    end
    #1;
    n_vec++;
    if ({t1_out_valid, t0_out_valid} !== 2'b00) begin n_err++; $display("FAIL b2b_end valid got %b want 00", {t1_out_valid, t0_out_valid}); end
    out_ready = 1'b0;
    tick();
    $display("back_to_back: v0=%h v1=%h", v[0], v[1]);
  endtask

  task automatic test_reset_mid();
    logic [31:0] x, y;
    logic [11:0] got, want;
    x = $urandom;
    in_valid = 1'b1; out_ready = 1'b1;
    d1_in = fwd_mux(x, 1'b1); d0_in = fwd_mux(x, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    want = {1'b1, 1'b0, 2'd1, x[P +: P]};
    got = {t1_out_valid, t1_in_ready, t1_out_row, t1_out_data};
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL rm_row1 got %h want %h", got, want); end
    reset = 1'b1;
    #1;
    want = {1'b0, 1'b1, 2'd0, 8'h00};
    got = {t1_out_valid, t1_in_ready, t1_out_row, t1_out_data};
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL rm_async_t1 got %h want %h", got, want); end
    got = {t0_out_valid, t0_in_ready, t0_out_row, t0_out_data};
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL rm_async_t0 got %h want %h", got, want); end
    tick();
    reset = 1'b0;
    tick();
    #1;
    n_vec++;
    if ({t1_out_valid, t1_in_ready} !== 2'b01) begin n_err++; $display("FAIL rm_after {v,rdy} got %b want 01", {t1_out_valid, t1_in_ready}); end
    y = $urandom;
    in_valid = 1'b1;
    d1_in = fwd_mux(y, 1'b1); d0_in = fwd_mux(y, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      #1;
      want = {1'b1, (i == N-1), 2'(i), y[i*P +: P]};
      got = {t1_out_valid, t1_in_ready, t1_out_row, t1_out_data};
      n_vec++;
      if (got !== want) begin n_err++; $display("FAIL rm_restart row %0d got %h want %h", i, got, want); end
      tick();
    end
    #1;
    n_vec++;
    if (t1_out_valid !== 1'b0) begin n_err++; $display("FAIL rm_end valid got %b want 0", t1_out_valid); end
    out_ready = 1'b0;
    $display("reset_mid: x=%h y=%h", x, y);
  endtask

  initial begin
    build_order();
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
    in_valid = 1'b0; out_ready = 1'b0; d1_in = '0; d0_in = '0;
    test_reset();
    test_basic();
    test_roundtrip();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/b_unmux_serializer.md
# b_unmux_serializer

Inverse of the spatial-multiplier B-operand mux, used for readback and debug. It accepts one quadrant-permuted B vector per transaction with a valid/ready handshake and buffers it. It then emits the operand in natural row-major order, one row of `PRECISION` bits per beat. It sits on the readback path between the spatial-multiplier operand registers and the debug/DMA stream.

## Interface

**Parameters**
- `PRECISION`, default 8: operand precision at the top level.
- `L_PRECISION`, default 2: lowest (digit) precision.
- `TRANSPOSE`, default 1: 1 means the input was permuted by a top-level (transposing) mux; 0 means a non-top mux.
- Derived `N` = `PRECISION/L_PRECISION`; `DATA_WIDTH` = `N*PRECISION`; `ROW_W` = `clog2(N)`, minimum 1.

**Ports**
- `clk`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-high.
- `in_valid`, input, 1: permuted vector present.
- `in_ready`, output, 1: block can accept a vector.
- `in_data`, input, `DATA_WIDTH`: permuted B vector.
- `out_valid`, output, 1: row present.
- `out_ready`, input, 1: consumer accepts the row.
- `out_data`, output, `PRECISION`: natural-order row.
- `out_row`, output, `ROW_W`: index of the current row.
- `out_last`, output, 1: present only with `B_UNMUX_ROW_LAST_EN`.

## Operation

**Data layout**
- The vector is an N×N grid of L-bit digits.
- Natural digit `(r,c)` sits at bits `[(c+r*N)*L +: L]`.
- Row r is output as `{d(r,N-1),…,d(r,0)}`, with column 0 at the LSB.

**Forward permutation (being inverted)**
- Non-top level, half-size `H=N/2`: quadrant q occupies bits `[q*DATA_WIDTH/4 +: DATA_WIDTH/4]`.
  - q0 = rows 0..H-1, cols 0..H-1.
  - q1 = rows 0..H-1, cols H..N-1.
  - q2 = rows H..N-1, cols 0..H-1.
  - q3 = rows H..N-1, cols H..N-1.
- Each quadrant is recursively permuted as a non-top level. The recursion ends at N=1 (identity).
- Top level with `TRANSPOSE=1`: the grid is transposed (`(r,c)` becomes `(c,r)`) first, then the non-top permutation is applied.

**Unmux**
- The block applies the exact inverse, so that `unmux(mux(x)) == x` for all x.
- The inverse is pure wiring, computed at elaboration.

**FSM**
- States are IDLE and SEND.
- IDLE: `in_ready=1`. When `in_valid` is high, the block captures the un-permuted vector into `buf`, sets `row=0`, and moves to SEND.
- SEND: `out_valid=1`, `out_data=buf` row `row`, `out_row=row`.
  - On `out_ready` with `row<N-1`: `row++`.
  - On `out_ready` with `row==N-1`: the transaction ends.
- Back-to-back transfers:
  - In SEND, `in_ready = (row==N-1) && out_ready`. This is combinational from `out_ready`.
  - If `in_valid` is also high, the new vector is captured, `row` becomes 0, and the state stays SEND. There is no bubble.
  - Otherwise the state returns to IDLE.
- `out_data` and `out_row` are held stable while `out_valid && !out_ready`.
- `in_data` is ignored unless the handshake completes.

**Degenerate case**
- N=1 (`PRECISION==L_PRECISION`): single-row transactions, and `out_row` is constant 0.

## Timing

**Reset (asynchronous)**
- State becomes IDLE.
- `buf=0`, `row=0`.
- `out_valid=0`, `out_data=0`, `out_row=0`, `out_last=0`.
- `in_ready=1` one delta after reset; it is asserted even while `reset` is high.

**Latency**
- A vector accepted at edge k gives `out_valid` high in the cycle after edge k.
- With continuous `out_ready`, row i is presented in cycle k+1+i.
- Throughput is one row per cycle. One vector occupies N cycles, sustained with no bubble.

**Reset mid-transaction**
- The current vector is discarded.
- No partial rows are emitted after reset deasserts.

## Configuration

- `B_UNMUX_ROW_LAST_EN` defined: adds output `out_last`, which equals `out_valid && row==N-1`. It resets to 0.
- Without the macro: the port is absent, and behaviour is otherwise identical.

## Structure

**Shared package `spatial_mult_pkg`**
- `clog2` function.
- Digit-index permutation function `b_mux_index(P, L, transpose, nat_idx)`. The forward mux and this block share it.

**Sub-module `b_unmux_perm`**
- Purely combinational, parameterised on `PRECISION`, `L_PRECISION` and `TRANSPOSE`.
- Maps `DATA_WIDTH` input to `DATA_WIDTH` output by generate loops over the package function.
- The top level holds the FSM, `buf`, `row` counter and row mux.

## Test plan

- **Transposed, basic:** P=4, L=2, TRANSPOSE=1; `in_data`=8'hD8, `out_ready`=1.
  - Expect row0 = 4'h4, then row1 = 4'hE.
  - `out_row` 0 then 1.
  - `out_valid` 1 cycle after acceptance.
- **Non-transposed, basic:** same but TRANSPOSE=0, `in_data`=8'hD8 → row0 = 4'h8, row1 = 4'hD.
- **Round trip:** P=8, L=2, both TRANSPOSE values; random x passed through a reference forward mux model.
  - Expect 4 rows that concatenate to x.
  - `out_last` high only on row 3 when the macro is defined.
- **Backpressure:** `out_ready` toggles 1,0,0,1.
  - `out_data` and `out_row` stay stable while stalled.
  - `in_ready` is 0 until the final row handshake.
- **Back-to-back:** `in_valid` held high with two vectors, `out_ready`=1.
  - Expect 2N consecutive `out_valid` cycles with no gap, and `in_ready` pulsing on each final row.
- **Reset mid-transaction:** assert `reset` during row 1 of 4.
  - `out_valid` drops asynchronously.
  - After release: IDLE, `in_ready`=1, and the next vector restarts at row 0.
